mux_sel_arbiter: RTL and testbench

Round-robin arbiter and select sequencer for the shared registered 4:1 data mux. Four requesters each present one data bit and a request. The block grants one requester at a time, drives the 2-bit select, and registers the selected bit, giving the mux output one cycle after the grant. It bounds each requester's tenure so that no requester starves.

---
 rtl/mux_arb_pkg.sv | 25 ++
 rtl/mux_sel_arbiter_rr_pick.sv | 36 +++
 rtl/mux_sel_arbiter.sv | 119 +++++++++++
 tb/tb_mux_sel_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// ============================================================================
// Module   : mux_arb_pkg
// Brief    : Shared constants, FSM state type and one-hot helper for the
//            round-robin mux select arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_arb_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_sel_arbiter_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin search: first set request at or after
//            ptr (mod 4), plus a found flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [SEL_W-1:0] w_cand;

  // Scan from farthest to nearest so the nearest set bit wins.
  always_comb begin
    idx    = '0;
    found  = 1'b0;
    w_cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = ptr + SEL_W'(k);
      if (req[w_cand]) begin
        idx   = w_cand;
        found = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_sel_arbiter.sv
// ============================================================================
// Module   : mux_sel_arbiter
// Brief    : Round-robin arbiter with bounded tenure driving the select and
//            registered output of a shared 4:1 data mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_sel_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  din,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             out,
  output logic             out_vld
);

  localparam logic [CNT_W-1:0] c_max_hold = CNT_W'(MAX_HOLD);

  state_t           r_state, w_state_nxt;
  logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_out, r_vld;

  logic [NREQ-1:0]  w_others, w_pick_req;
  logic [SEL_W-1:0] w_pick_idx;
  logic             w_pick_found, w_at_limit, w_keep;

  assign w_others   = req & ~onehot(r_sel);
  assign w_pick_req = (r_state == IDLE) ? req : w_others;
  assign w_at_limit = (r_cnt >= c_max_hold);
  // The holder stays while it still requests and is under budget, or nobody else waits.
  assign w_keep     = req[r_sel] && (!w_at_limit || (w_others == '0));

  rr_pick u_pick (
    .req   (w_pick_req),
    .ptr   (r_ptr),
    .idx   (w_pick_idx),
    .found (w_pick_found)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_found) w_state_nxt = GRANT;
      GRANT:   if (!w_keep && !w_pick_found) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_gnt_nxt = '0;
    w_sel_nxt = r_sel;
    w_cnt_nxt = '0;
    w_ptr_nxt = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_pick_found) begin
          w_gnt_nxt = onehot(w_pick_idx);
          w_sel_nxt = w_pick_idx;
          w_cnt_nxt = CNT_W'(1);
          w_ptr_nxt = w_pick_idx + SEL_W'(1);
        end
      end
      GRANT: begin
        if (w_keep) begin
          w_gnt_nxt = onehot(r_sel);
          w_cnt_nxt = w_at_limit ? CNT_W'(1) : r_cnt + CNT_W'(1);
        end else if (w_pick_found) begin
          w_gnt_nxt = onehot(w_pick_idx);
          w_sel_nxt = w_pick_idx;
          w_cnt_nxt = CNT_W'(1);
          w_ptr_nxt = w_pick_idx + SEL_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gnt <= '0;
      r_sel <= '0;
      r_cnt <= '0;
      r_ptr <= '0;
      r_out <= 1'b0;
      r_vld <= 1'b0;
    end else begin
      r_gnt <= w_gnt_nxt;
      r_sel <= w_sel_nxt;
      r_cnt <= w_cnt_nxt;
      r_ptr <= w_ptr_nxt;
      if (|r_gnt) r_out <= din[r_sel];
      r_vld <= |r_gnt;
    end
  end

  assign gnt     = r_gnt;
  assign sel     = r_sel;
  assign out     = r_out;
  assign out_vld = r_vld;

endmodule

`default_nettype wire

// File: tb/tb_mux_sel_arbiter.sv
// ============================================================================
// Module   : tb_mux_sel_arbiter
// Brief    : Self-checking bench; two arbiters (MAX_HOLD 4 and 1) share stimulus
//            and are compared each cycle against a tenure-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, din;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] sel_a, sel_b;
  logic       out_a, out_b, vld_a, vld_b;

  always #5 clk = ~clk;

  mux_sel_arbiter #(.MAX_HOLD(4), .CNT_W(3)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .gnt(gnt_a), .sel(sel_a), .out(out_a), .out_vld(vld_a)
  );

  mux_sel_arbiter #(.MAX_HOLD(1), .CNT_W(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .gnt(gnt_b), .sel(sel_b), .out(out_b), .out_vld(vld_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who holds the grant, how long it has held, and the round-robin start.
  int   m_hold[2];
  int   m_ten[2];
  int   m_ptr[2];
  int   m_sel[2];
  logic m_out[2];
  logic m_vld[2];
  int   mh[2] = '{4, 1};

  function automatic int first_from(input int start, input logic [3:0] r);
    for (int k = 0; k < 4; k++)
      if (r[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  task automatic give(input int i, input int p);
    m_hold[i] = p;
    m_ten[i]  = 1;
    m_ptr[i]  = (p + 1) % 4;
    m_sel[i]  = p;
  endtask

  task automatic model_step(input int i);
    logic [3:0] others;
    int p;
    if (!rst_n) begin
      m_hold[i] = -1; m_ten[i] = 0; m_ptr[i] = 0; m_sel[i] = 0;
      m_out[i]  = 1'b0; m_vld[i] = 1'b0;
      return;
    end
    if (m_hold[i] >= 0) m_out[i] = din[m_sel[i]];
    m_vld[i] = (m_hold[i] >= 0);
    if (m_hold[i] < 0) begin
      p = first_from(m_ptr[i], req);
      if (p >= 0) give(i, p);
    end else begin
      others = req;
      others[m_hold[i]] = 1'b0;
      if (req[m_hold[i]] && (m_ten[i] < mh[i] || others == 4'b0)) begin
        m_ten[i] = (m_ten[i] < mh[i]) ? m_ten[i] + 1 : 1;
      end else begin
        p = first_from(m_hold[i] + 1, others);
        if (p >= 0) give(i, p);
        else        m_hold[i] = -1;
      end
    end
  endtask

  function automatic logic [31:0] exp_gnt(input int i);
    return (m_hold[i] < 0) ? 32'd0 : (32'd1 << m_hold[i]);
  endfunction

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    #1;
    chk("gnt_h4", gnt_a, exp_gnt(0));
    chk("sel_h4", sel_a, m_sel[0]);
    chk("out_h4", out_a, m_out[0]);
    chk("vld_h4", vld_a, m_vld[0]);
    chk("gnt_h1", gnt_b, exp_gnt(1));
    chk("sel_h1", sel_b, m_sel[1]);
    chk("out_h1", out_b, m_out[1]);
    chk("vld_h1", vld_b, m_vld[1]);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [3:0] exp_data;

  initial begin
    rst_n = 1'b0; req = 4'hF; din = 4'hF;

    // Reset holds everything low despite full requests.
    repeat (3) begin
      step();
      chk("rst_gnt", gnt_a, 4'b0000);
      chk("rst_sel", sel_a, 2'd0);
      chk("rst_out", out_a, 1'b0);
      chk("rst_vld", vld_a, 1'b0);
    end
    rst_n = 1'b1;

    // Full contention: 4-cycle tenures for MAX_HOLD=4, per-cycle rotation for MAX_HOLD=1.
    for (int k = 0; k < 20; k++) begin
      step();
      chk("rot_h4", gnt_a, 32'd1 << ((k / 4) % 4));
      chk("rot_h1", gnt_b, 32'd1 << (k % 4));
      if (k == 1) begin
        chk("first_out", out_a, 1'b1);
        chk("first_vld", vld_a, 1'b1);
      end
    end

    // Data path with rotation every cycle.
    rst_n = 1'b0; din = 4'b1010; step(); rst_n = 1'b1;
    exp_data = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k < 4) chk("dp_gnt", gnt_b, 32'd1 << k);
      if (k >= 1) begin
        chk("dp_out", out_b, exp_data[k-1]);
        chk("dp_vld", vld_b, 1'b1);
      end
    end

    // Lone requester is re-granted with no gap.
    rst_n = 1'b0; req = 4'b0100; din = 4'hF; step(); rst_n = 1'b1;
    repeat (10) begin
      step();
      chk("lone_gnt", gnt_a, 4'b0100);
      chk("lone_sel", sel_a, 2'd2);
    end
    req = 4'b0000;
    step(); chk("drop_gnt", gnt_a, 4'b0000);
    step(); chk("drop_vld", vld_a, 1'b0);

    // Early release hands over directly; pointer then wraps to 0.
    rst_n = 1'b0; req = 4'b0010; step(); rst_n = 1'b1;
    step(); step();
    req = 4'b1000;
    step(); chk("early_gnt", gnt_a, 4'b1000); chk("early_sel", sel_a, 2'd3);
    req = 4'b0011;
    step(); chk("ptr_wrap", gnt_a, 4'b0001);

    // Reset in the middle of a tenure restarts the pointer.
    rst_n = 1'b0; req = 4'b0100; step(); rst_n = 1'b1;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    chk("mid_gnt", gnt_a, 4'b0000); chk("mid_sel", sel_a, 2'd0);
    chk("mid_out", out_a, 1'b0);    chk("mid_vld", vld_a, 1'b0);
    rst_n = 1'b1; req = 4'b0110;
    step(); chk("mid_regrant", gnt_a, 4'b0010);

    // Randomized traffic with sticky requests and occasional resets.
    repeat (400) begin
      if ($urandom_range(0, 2) == 0) req = 4'($urandom_range(0, 15));
      din   = 4'($urandom_range(0, 15));
      rst_n = ($urandom_range(0, 63) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
